fwd_round_tf: RTL and testbench
===============================

FWD_ROUND_TF -- requirements
Module: fwd_round_tf

Interface
REQ-001 The block SHALL have parameter SBOX_PAR, default 16, meaning S-box bytes substituted per clock; legal values 1, 2, 4, 8, 16; any other value SHALL fail elaboration.
REQ-002 The block SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port start_i, input, 1 bit: request to start one forward round on s_i.
REQ-005 The block SHALL have port bypass_mc_i, input, 1 bit: 1 = skip MixColumns (final AES round).
REQ-006 The block SHALL have port s_i, input, 128 bits: state in; byte b = s_i[127-8b -: 8], column-major AES order.
REQ-007 The block SHALL have port s_o, output, 128 bits: registered result, same byte order.
REQ-008 The block SHALL have port done_o, output, 1 bit: one-cycle pulse, s_o valid.
REQ-009 The block SHALL have port busy_o, output, 1 bit: high while a round is in progress.

Function
REQ-010 The block SHALL compute s_o = MixColumns(ShiftRows(SubBytes(s_i))) per FIPS-197, or ShiftRows(SubBytes(s_i)) when the captured bypass bit is 1; no AddRoundKey.
REQ-011 The block SHALL implement the FSM states IDLE, SUB and FIN; busy_o SHALL equal (state != IDLE).
REQ-012 In IDLE, start_i=1 at edge E0 SHALL load s_i into the internal state register, capture bypass_mc_i, clear chunk counter cnt, and enter SUB.
REQ-013 In SUB, each edge SHALL replace bytes cnt*SBOX_PAR .. cnt*SBOX_PAR+SBOX_PAR-1 with their forward S-box values and increment cnt; after N = 16/SBOX_PAR edges the FSM SHALL enter FIN.
REQ-014 cnt SHALL be ceil(log2(N)) bits, minimum 1, and SHALL not wrap inside a round.
REQ-015 In FIN, the next edge SHALL register the ShiftRows/MixColumns result into s_o, pulse done_o high for exactly one cycle, and return to IDLE.
REQ-016 done_o SHALL rise at edge E0+N+1 (PAR=16: 2 edges after E0; PAR=1: 17 edges after E0).
REQ-017 s_o SHALL hold its value until the next done_o; it SHALL not change during SUB or FIN.
REQ-018 start_i while busy_o=1 SHALL be ignored, with no effect on state, result or timing.
REQ-019 start_i=1 in the cycle done_o=1 (FSM in IDLE) SHALL be accepted, giving back-to-back rounds with no idle cycle.
REQ-020 Changes on s_i or bypass_mc_i after E0 SHALL not affect the round in progress.
REQ-021 The S-box SHALL be the FIPS-197 forward table, combinational, SBOX_PAR instances sharing nothing between lanes.

Reset
REQ-022 rst_n=0 at an edge SHALL force state=IDLE, cnt=0, s_o=128'h0, done_o=0, busy_o=0, captured bypass=0, internal state register=0.
REQ-023 Reset asserted mid-round (SUB or FIN) SHALL abort the round with no done_o pulse; start_i is ignored at any edge where rst_n=0.
REQ-024 After reset release, the first start_i SHALL behave per REQ-012 with no extra latency.

Verification
REQ-025 FIPS-197 App.B round 1, bypass=0, s_i=193de3bea0f4e22b9ac68d2ae9f84808 -> s_o=046681e5e0cb199a48f8d37a2806264c, done_o exactly at E0+N+1, for every legal SBOX_PAR.
REQ-026 Same s_i, bypass=1 -> s_o=d4bf5d30e0b452aeb84111f11e2798e5; s_i=0 with bypass 0 or 1 -> s_o=63636363636363636363636363636363.
REQ-027 SBOX_PAR=4, pulse start_i again at E0+1 and E0+3 with different s_i -> ignored; single done_o at E0+5 with the first round's result.
REQ-028 Back-to-back: start_i held high through done_o cycle with a new s_i -> second done_o exactly N+2 edges after the first, both results correct.
REQ-029 rst_n=0 for one edge during SUB (SBOX_PAR=2, edge E0+3) -> no done_o, s_o=0, busy_o=0 next cycle; a following start completes normally.
REQ-030 Random: 1000 random s_i/bypass values per legal SBOX_PAR against a reference model -> zero mismatches, done_o count equals accepted starts.

Source files
------------

// File: rtl/fwd_round_tf.sv
// AES forward round without AddRoundKey: SubBytes spread over 16/SBOX_PAR cycles,
// then ShiftRows and (unless bypassed) MixColumns, registered into s_o.
module fwd_round_tf #(
    parameter int SBOX_PAR = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         bypass_mc_i,
    input  logic [127:0] s_i,
    output logic [127:0] s_o,
    output logic         done_o,
    output logic         busy_o
);

    localparam int N       = 16 / SBOX_PAR;
    localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int CHUNK_W = 8 * SBOX_PAR;

    if (!(SBOX_PAR == 1 || SBOX_PAR == 2 || SBOX_PAR == 4 ||
          SBOX_PAR == 8 || SBOX_PAR == 16)) begin : g_bad_par
        $error("fwd_round_tf: SBOX_PAR must be 1, 2, 4, 8 or 16");
    end

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIN  = 2'd2
    } state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte (row r, column c) sits at index r + 4c; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [127:0]         st_q, st_d;
    logic                 byp_q, byp_d;
    logic [127:0]         so_q, so_d;
    logic                 done_q, done_d;
    logic [6:0]           base_s;
    logic [CHUNK_W-1:0]   chunk_in_s, chunk_out_s;
    logic [127:0]         round_res_s;

    // Select the chunk of bytes being substituted this cycle.
    always_comb begin
        base_s     = 7'(127 - int'(cnt_q) * CHUNK_W);
        chunk_in_s = st_q[base_s -: CHUNK_W];
    end

    for (genvar l = 0; l < SBOX_PAR; l++) begin : g_lane
        assign chunk_out_s[CHUNK_W - 1 - 8 * l -: 8] = sbox(chunk_in_s[CHUNK_W - 1 - 8 * l -: 8]);
    end

    // ShiftRows then optional MixColumns on the fully substituted state.
    always_comb begin
        round_res_s = shift_rows(st_q);
        if (!byp_q) begin
            round_res_s = mix_columns(round_res_s);
        end else begin
            round_res_s = round_res_s;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        byp_d   = byp_q;
        so_d    = so_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    st_d    = s_i;
                    byp_d   = bypass_mc_i;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = SUB;
                end else begin
                    state_d = IDLE;
                end
            end
            SUB: begin
                st_d[base_s -: CHUNK_W] = chunk_out_s;
                // Hold cnt on the last chunk so it never wraps within a round.
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIN: begin
                so_d    = round_res_s;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            st_q    <= 128'h0;
            byp_q   <= 1'b0;
            so_q    <= 128'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            byp_q   <= byp_d;
            so_q    <= so_d;
            done_q  <= done_d;
        end
    end

    assign s_o    = so_q;
    assign done_o = done_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_fwd_round_tf.sv
// Bench for fwd_round_tf: one instance per legal SBOX_PAR, scoreboard of expected
// results/done cycles checked against an independently built AES round model.
module tb_fwd_round_tf;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start [5];
    logic         byp   [5];
    logic         done  [5];
    logic         busy  [5];
    logic [127:0] s_in  [5];
    logic [127:0] s_out [5];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        fwd_round_tf #(.SBOX_PAR(1 << g)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start_i    (start[g]),
            .bypass_mc_i(byp[g]),
            .s_i        (s_in[g]),
            .s_o        (s_out[g]),
            .done_o     (done[g]),
            .busy_o     (busy[g])
        );
    end

    typedef struct {
        logic [127:0] s;
        int           cyc;
    } exp_t;

    typedef struct {
        logic [127:0] s_in;
        logic         byp;
        logic [127:0] exp;
    } vec_t;

    exp_t       sbq[$];
    logic [7:0] sb[256];
    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         cur      = 0;
    int         done_cnt = 0;
    int         acc_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse plus affine map, not from a copied table.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, r, s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ 8'h63;
            r = inv;
            for (int j = 0; j < 4; j++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sb[x] = s;
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s, input logic b);
        logic [7:0]   a[16];
        logic [7:0]   t[16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sb[s[127 - 8 * i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r + 4 * c] = a[r + 4 * ((c + r) % 4)];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (b) o[127 - 8 * (r + 4 * c) -: 8] = t[r + 4 * c];
                else   o[127 - 8 * (r + 4 * c) -: 8] = gmul(8'h02, t[r + 4 * c]) ^
                                                        gmul(8'h03, t[(r + 1) % 4 + 4 * c]) ^
                                                        t[(r + 2) % 4 + 4 * c] ^ t[(r + 3) % 4 + 4 * c];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s par=%0d: got %h, expected %h", name, 1 << cur, got, exp);
        end
    endtask

    // Scoreboard side: every done pulse of the DUT under test pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done[cur] === 1'b1) begin
                done_cnt++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done par=%0d: got done at cycle %0d, expected none", 1 << cur, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("s_o", s_out[cur], e.s);
                    chk("done_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
        end
    end

    // Start one round from idle; E0 is the next edge, done expected at E0+N+1.
    task automatic issue(input int k, input logic [127:0] s, input logic b, input logic [127:0] exp);
        logic [127:0] prev;
        prev     = s_out[k];
        start[k] = 1'b1;
        s_in[k]  = s;
        byp[k]   = b;
        sbq.push_back('{exp, cyc + 1 + (16 >> k) + 1});
        acc_cnt++;
        tick();
        start[k] = 1'b0;
        s_in[k]  = {$urandom, $urandom, $urandom, $urandom};
        byp[k]   = ~b;
        chk("busy_after_start", 128'(busy[k]), 128'(1));
        chk("s_o_hold", s_out[k], prev);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout par=%0d: got %0d pending results, expected 0", 1 << cur, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        vec_t         vt[4];
        logic [127:0] sa, sb2;
        logic         bb;
        int           n;

        vt[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c};
        vt[1] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
        vt[2] = '{128'h0, 1'b0, 128'h63636363636363636363636363636363};
        vt[3] = '{128'h0, 1'b1, 128'h63636363636363636363636363636363};

        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            start[k] = 1'b0;
            byp[k]   = 1'b0;
            s_in[k]  = 128'h0;
        end
        build_sbox();
        repeat (3) tick();
        for (int k = 0; k < 5; k++) begin
            cur = k;
            chk("reset_s_o", s_out[k], 128'h0);
            chk("reset_done", 128'(done[k]), 128'(0));
            chk("reset_busy", 128'(busy[k]), 128'(0));
        end
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) begin
            cur      = k;
            n        = 16 >> k;
            done_cnt = 0;
            acc_cnt  = 0;

            for (int v = 0; v < 4; v++) begin
                issue(k, vt[v].s_in, vt[v].byp, vt[v].exp);
                drain();
            end

            // Back-to-back: start held through the done cycle with a new state.
            sa       = {$urandom, $urandom, $urandom, $urandom};
            sb2      = {$urandom, $urandom, $urandom, $urandom};
            start[k] = 1'b1;
            s_in[k]  = sa;
            byp[k]   = 1'b0;
            sbq.push_back('{model(sa, 1'b0), cyc + 1 + n + 1});
            tick();
            sbq.push_back('{model(sb2, 1'b1), cyc + n + 1 + n + 2});
            s_in[k]  = sb2;
            byp[k]   = 1'b1;
            repeat (n + 2) tick();
            start[k] = 1'b0;
            acc_cnt += 2;
            drain();

            if (k == 2) begin
                // Starts at E0+1 and E0+3 land while busy and must be ignored.
                sa       = {$urandom, $urandom, $urandom, $urandom};
                start[k] = 1'b1;
                s_in[k]  = sa;
                byp[k]   = 1'b0;
                sbq.push_back('{model(sa, 1'b0), cyc + 1 + 5});
                acc_cnt++;
                tick();
                s_in[k]  = ~sa;
                byp[k]   = 1'b1;
                tick();
                start[k] = 1'b0;
                tick();
                start[k] = 1'b1;
                s_in[k]  = sa ^ 128'h5a5a;
                tick();
                start[k] = 1'b0;
                drain();
                repeat (10) tick();
            end

            if (k == 1) begin
                // Reset for one edge at E0+3 aborts the round silently.
                start[k] = 1'b1;
                s_in[k]  = vt[0].s_in;
                byp[k]   = 1'b0;
                tick();
                start[k] = 1'b0;
                repeat (2) tick();
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                chk("abort_s_o", s_out[k], 128'h0);
                chk("abort_busy", 128'(busy[k]), 128'(0));
                chk("abort_done", 128'(done[k]), 128'(0));
                repeat (20) tick();
                issue(k, vt[0].s_in, 1'b0, vt[0].exp);
                drain();
            end

            for (int r = 0; r < 1000; r++) begin
                sa = {$urandom, $urandom, $urandom, $urandom};
                bb = 1'($urandom_range(0, 1));
                issue(k, sa, bb, model(sa, bb));
                drain();
            end

            checks++;
            if (done_cnt != acc_cnt) begin
                errors++;
                $display("FAIL done_count par=%0d: got %0d, expected %0d", 1 << k, done_cnt, acc_cnt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
